// File: rtl/sync_pkg.sv
// Shared constants and helpers for the async-input conditioner.
//   DEF_STAGES / DEF_FILT_CNT : default synchroniser depth and filter length
//   MIN_STAGES                : shallowest legal synchroniser chain
//   cnt_w(filt)               : width of the stability counter for a given
//                               filter length, never less than one bit
package sync_pkg;

    localparam int DEF_STAGES   = 2;
    localparam int DEF_FILT_CNT = 4;
    localparam int MIN_STAGES   = 2;

    // max(1, clog2(filt)): the counter only has to reach filt-1.
    function automatic int cnt_w(input int filt);
        int w;
        w = $clog2(filt);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel of the conditioner: synchroniser chain, stability filter and
// registered edge detector.
//   clk   : sole clock, posedge
//   rst_n : synchronous active-low reset
//   d     : asynchronous level input
//   q     : synchronised, filtered level
//   rise  : one-cycle pulse on the edge where q goes 0->1
//   fall  : one-cycle pulse on the edge where q goes 1->0
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   STAGES   = DEF_STAGES,
    parameter int   FILT_CNT = DEF_FILT_CNT,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_w(FILT_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CNT - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              q_q, q_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              ys;

    // Plain shift: sync_q[0] is the only flop that can go metastable and
    // its sole reader is sync_q[1].
    assign sync_d = {sync_q[STAGES-2:0], d};
    assign ys     = sync_q[STAGES-1];

    // The counter tracks consecutive cycles of disagreement between ys and
    // q; any agreement wipes it, so interrupted glitches earn no credit.
    always_comb begin
        cnt_d  = '0;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (ys != q_q) begin
            if (cnt_q == CNT_MAX) begin
                q_d    = ys;
                rise_d = ys & ~q_q;
                fall_d = ~ys & q_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_BIT}};
            cnt_q  <= '0;
            q_q    <= RST_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-channel conditioner for asynchronous level inputs (pads, interrupts,
// straps). Each bit is synchronised, glitch-filtered and edge-detected
// independently.
//   CLOCK      : sole clock, posedge
//   RESETN     : synchronous active-low reset
//   d          : asynchronous level inputs, WIDTH bits
//   q          : synchronised, filtered levels
//   rise/fall  : one-cycle edge pulses per channel
//   any_change : OR of every rise and fall bit (registered sources only)
module sync_filter_edge
    import sync_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               STAGES   = DEF_STAGES,
    parameter int               FILT_CNT = DEF_FILT_CNT,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             CLOCK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    // Reject illegal parameterisations while elaborating.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_filter_edge: WIDTH must be >= 1");
    end
    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("sync_filter_edge: STAGES must be >= 2");
    end
    if (FILT_CNT < 1) begin : g_bad_filt
        $error("sync_filter_edge: FILT_CNT must be >= 1");
    end

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
        sync_filter_chan #(
            .STAGES  (STAGES),
            .FILT_CNT(FILT_CNT),
            .RST_BIT (RST_VAL[gi])
        ) u_chan (
            .clk  (CLOCK),
            .rst_n(RESETN),
            .d    (d[gi]),
            .q    (q[gi]),
            .rise (rise[gi]),
            .fall (fall[gi])
        );
    end

    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_sync_filter_edge.sv
// Bench for sync_filter_edge: two instances (default 8-bit build, and a
// 1-bit STAGES=3 / FILT_CNT=1 build) share clock and reset. A window-based
// reference model pushes the expected outputs of every edge into a queue per
// instance; a monitor pops and compares one cycle's worth of outputs.
module tb_sync_filter_edge;

    localparam int S0 = 2, F0 = 4;
    localparam int S1 = 3, F1 = 1;
    localparam logic [7:0] RST0 = 8'h00;
    localparam logic [7:0] RST1 = 8'h00;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] d0, q0, r0, f0;
    logic       a0;
    logic [0:0] d1, q1, r1, f1;
    logic       a1;

    always #5 clk = ~clk;

    sync_filter_edge #(.WIDTH(8), .STAGES(S0), .FILT_CNT(F0), .RST_VAL(RST0)) dut0 (
        .CLOCK(clk), .RESETN(rstn), .d(d0), .q(q0), .rise(r0), .fall(f0), .any_change(a0)
    );

    sync_filter_edge #(.WIDTH(1), .STAGES(S1), .FILT_CNT(F1), .RST_VAL(RST1[0:0])) dut1 (
        .CLOCK(clk), .RESETN(rstn), .d(d1), .q(q1), .rise(r1), .fall(f1), .any_change(a1)
    );

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state. dh: input samples, newest first (index k = d
    // taken k edges ago). yh: synchronised value after each edge, newest
    // first. A channel's q flips on an edge exactly when the last FILT_CNT
    // synchronised values all disagree with q.
    logic [7:0] dh0[16], yh0[16], mq0;
    logic [7:0] dh1[16], yh1[16], mq1;

    function automatic logic [7:0] flips(input logic [7:0] yh[16], input logic [7:0] qv, input int f);
        logic [7:0] m;
        m = 8'hFF;
        for (int j = 0; j < f; j++) m &= yh[j] ^ qv;
        return m;
    endfunction

    initial begin : model0
        exp_t e;
        logic [7:0] fl;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                for (int i = 0; i < 16; i++) begin dh0[i] = RST0; yh0[i] = RST0; end
                mq0 = RST0;
                e = '{q: RST0, rise: 8'h00, fall: 8'h00, any: 1'b0};
            end else begin
                fl  = flips(yh0, mq0, F0);
                mq0 = mq0 ^ fl;
                e   = '{q: mq0, rise: fl & mq0, fall: fl & ~mq0, any: |fl};
                for (int i = 15; i > 0; i--) begin dh0[i] = dh0[i-1]; yh0[i] = yh0[i-1]; end
                dh0[0] = d0;
                yh0[0] = dh0[S0-1];
            end
            sb0.push_back(e);
        end
    end

    initial begin : model1
        exp_t e;
        logic [7:0] fl;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                for (int i = 0; i < 16; i++) begin dh1[i] = RST1; yh1[i] = RST1; end
                mq1 = RST1;
                e = '{q: RST1, rise: 8'h00, fall: 8'h00, any: 1'b0};
            end else begin
                fl  = flips(yh1, mq1, F1);
                mq1 = mq1 ^ fl;
                e   = '{q: mq1, rise: fl & mq1, fall: fl & ~mq1, any: |fl};
                for (int i = 15; i > 0; i--) begin dh1[i] = dh1[i-1]; yh1[i] = yh1[i-1]; end
                dh1[0] = {7'b0, d1};
                yh1[0] = dh1[S1-1];
            end
            sb1.push_back(e);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at t=%0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0.sb: got empty queue required one entry at t=%0t", $time);
            end else begin
                e = sb0.pop_front();
                chk("dut0.q",         q0,          e.q);
                chk("dut0.rise",      r0,          e.rise);
                chk("dut0.fall",      f0,          e.fall);
                chk("dut0.any",       {7'b0, a0},  {7'b0, e.any});
                chk("dut0.rise&fall", r0 & f0,     8'h00);
            end
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1.sb: got empty queue required one entry at t=%0t", $time);
            end else begin
                e = sb1.pop_front();
                chk("dut1.q",    {7'b0, q1}, e.q);
                chk("dut1.rise", {7'b0, r1}, e.rise);
                chk("dut1.fall", {7'b0, f1}, e.fall);
                chk("dut1.any",  {7'b0, a1}, {7'b0, e.any});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic txn(input string what);
        $display("TXN t=%0t %s rstn=%0b d0=%h d1=%0b", $time, what, rstn, d0, d1);
    endtask

    initial begin : driver
        logic [7:0] nd0;
        logic       nd1, nr;
        rstn = 1'b0; d0 = 8'hFF; d1 = 1'b0;
        txn("reset with d0=ff");
        cyc(3);
        rstn = 1'b1;                  txn("release");          cyc(10);
        d0 = 8'h00;                   txn("all low");          cyc(10);
        d0 = 8'h01; d1 = 1'b1;        txn("bit0 rise");        cyc(10);
        d0 = 8'h09;                   txn("bit3 3-cycle");     cyc(3);
        d0 = 8'h01;                   txn("bit3 low");         cyc(10);
        d0 = 8'h09;                   txn("bit3 4-cycle");     cyc(4);
        d0 = 8'h01;                   txn("bit3 low");         cyc(12);
        d1 = 1'b0;                    txn("dut1 low");         cyc(8);
        d1 = 1'b1;                    txn("dut1 glitch");      cyc(1);
        d1 = 1'b0;                    txn("dut1 glitch end");  cyc(8);
        d0 = 8'h00;                   txn("all low");          cyc(10);
        d0 = 8'hA5;                   txn("a5 rise");          cyc(10);
        d0 = 8'h00;                   txn("a5 fall");          cyc(10);
        d0 = 8'h02;                   txn("bit1 rise");        cyc(3);
        rstn = 1'b0;                  txn("reset mid-flight"); cyc(1);
        rstn = 1'b1;                  txn("release");          cyc(10);
        for (int i = 0; i < 400; i++) begin
            nd0 = d0;
            nd1 = d1;
            nr  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) nd0 = d0 ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 5) == 0) nd1 = ~d1;
            if (nd0 != d0 || nd1 != d1 || nr != rstn) begin
                d0 = nd0; d1 = nd1; rstn = nr;
                txn("random");
            end
            cyc(1);
        end
        rstn = 1'b1;                  txn("settle");           cyc(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_filter_edge.md
Name: sync_filter_edge

Overview:
Parametrised multi-bit input conditioner for asynchronous level inputs such as pads, interrupts and straps. Each channel passes through a configurable-depth synchroniser chain, then a per-channel stability (glitch) filter, then an edge detector that emits one-cycle rise/fall pulses. It sits between async input sources and APB-side peripheral logic, in the CLOCK domain.

Parameters:
- WIDTH, 8, number of independent channels (>=1).
- STAGES, 2, synchroniser flops per channel (>=2).
- FILT_CNT, 4, consecutive cycles the synchronised value must differ from q before q updates (>=1; 1 = no filtering, one register only).
- RST_VAL, {WIDTH{1'b0}}, reset value of q and of every synchroniser flop, per channel.

Ports:
- CLOCK  in  1  sole clock; all flops on posedge.
- RESETN  in  1  reset; synchronous, active-low, sampled on posedge CLOCK.
- d  in  WIDTH  asynchronous level inputs.
- q  out  WIDTH  synchronised, filtered level.
- rise  out  WIDTH  one-cycle pulse per channel when q goes 0->1.
- fall  out  WIDTH  one-cycle pulse per channel when q goes 1->0.
- any_change  out  1  OR-reduction of (rise | fall); combinational from registered outputs only.

Behaviour:
- Reset: a posedge with RESETN=0 loads sync flops with RST_VAL, q with RST_VAL, counters with 0, and rise/fall/any_change with 0. The value of d is ignored during reset.
- Sync chain per channel: s[0]<=d[i], s[k]<=s[k-1]; ys = s[STAGES-1].
- Filter per channel with counter cnt, width max(1,clog2(FILT_CNT)):
  - ys==q: cnt<=0, q holds.
  - ys!=q and cnt<FILT_CNT-1: cnt<=cnt+1, q holds.
  - ys!=q and cnt==FILT_CNT-1: q<=ys, cnt<=0.
- rise/fall are registered and update on the same edge as q:
  - rise[i]<=(ys & ~q) on the update edge, 0 otherwise.
  - fall[i] is the mirror of rise[i].
  - Each pulse is exactly one cycle, and rise and fall are never both 1 on the same channel.
- Latency: let E0 be the first edge that samples the new stable d.
  - ys changes after E0+STAGES-1.
  - q and the pulse change after E0+STAGES+FILT_CNT-1. With the defaults, that is E0+5.
- Glitch rejection: ys deviating from q for fewer than FILT_CNT consecutive cycles gives no q change and no pulse. Returning to equality clears cnt, so there is no partial credit.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses.
- Reset mid-operation: pending counts and in-flight sync values are discarded, and any pulse in the reset cycle is dropped.
- After release: if d==RST_VAL, no pulse ever occurs. If d!=RST_VAL, a normal edge pulse occurs after full latency. This is intended behaviour.
- Metastability: only s[0] may go metastable. No logic other than s[1] reads s[0].

Decomposition:
- Shared package sync_pkg holds:
  - DEF_STAGES=2, DEF_FILT_CNT=4, MIN_STAGES=2.
  - A cnt_w(filt) constant function returning max(1,clog2(filt)).
- One sub-module, sync_filter_chan: a single channel containing the chain, counter, q, rise and fall.
- The top instantiates WIDTH copies in a generate loop, adds the any_change OR-reduction, and checks parameter legality at elaboration.

Test Plan:
1. Defaults, d=8'hFF held through 3 reset cycles then release -> during reset q=8'h00, rise=fall=0. Then q=8'hFF with rise=8'hFF for one cycle after E0+5, where E0 is the first post-release edge.
2. From q=0, d[0] 0->1 held, sampled at E0 -> q[0]=1 after E0+5, rise[0]=1 exactly that cycle, fall=0, other bits unchanged, any_change=1 for one cycle.
3. d[3] high for 3 cycles then low -> q[3] stays 0, no rise. Same pulse for 4 cycles -> q[3]=1 with rise[3] pulse, then after return q[3]=0 with fall[3] pulse.
4. d 8'h00->8'hA5, then later ->8'h00 -> rise=8'hA5 for one cycle, then fall=8'hA5 for one cycle. rise&fall==0 at all times.
5. d[1] rises at E0, RESETN=0 at edge E0+3 for 1 cycle, d held high -> no rise in the window. After release, q[1]=1 after a full 5-cycle latency from the first post-release edge.
6. STAGES=3, FILT_CNT=1, WIDTH=1, d 0->1 at E0 -> q=1 with rise after E0+3. A 1-cycle glitch (d high only during the single sampling edge E0, held low otherwise) is NOT rejected and gives rise then fall pulses.
